// File: rtl/bus_drvr_fifo_if.sv
// Arbiter-facing handshake bundle for bus_drvr_fifo.
// The master side is the bus driver; the slave side is the FIFO.
interface bus_drvr_fifo_if #(
    parameter int PCKG  = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            push;
    logic [PCKG-1:0] D_push;
    logic            pop;
    logic [PCKG-1:0] D_pop;
    logic            pndng;
    logic            full;
    logic            almost_full;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;
    logic            clr_flags;

    modport master (
        output push, D_push, pop, clr_flags,
        input  D_pop, pndng, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, D_push, pop, clr_flags,
        output D_pop, pndng, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/bus_drvr_fifo.sv
// Show-ahead FIFO between a bus driver and the arbiter, with any-depth pointer wrap,
// drop/overwrite policy on a full write, occupancy count and sticky error flags.
module bus_drvr_fifo #(
    parameter int PCKG   = 16,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int MODE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    bus_drvr_fifo_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic OVERWRITE = (MODE == 1);

    logic [PCKG-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop_ok;
    logic            w_wr_en;
    logic            w_rd_adv;
    logic            w_ovf_set;
    logic            w_udf_set;
    logic [PW-1:0]   w_wr_ptr_nxt;
    logic [PW-1:0]   w_rd_ptr_nxt;

    // Explicit compare keeps the wrap correct for non-power-of-two depths.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop_ok     = bus.pop & ~w_empty;
    assign w_ovf_set    = bus.push & ~bus.pop & w_full;
    assign w_udf_set    = bus.pop & w_empty;
    assign w_wr_en      = bus.push & (~w_full | bus.pop | OVERWRITE);
    // An overwriting write on a full FIFO discards the oldest word by moving the head too.
    assign w_rd_adv     = w_pop_ok | (w_ovf_set & OVERWRITE);
    assign w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
    assign w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.D_push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_wr_en && !w_rd_adv) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_adv && !w_wr_en) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A new error in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clr_flags);
            r_underflow <= w_udf_set | (r_underflow & ~bus.clr_flags);
        end
    end

    assign bus.D_pop       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.pndng       = ~w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= CW'(AF_LVL));
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule
